// File: rtl/sqrt_seq_ctrl_if.sv
// Start/done handshake between the operand source / result consumer and sqrt_seq_ctrl.
// The remainder signal exists only when SQRT_REMAINDER_EN is defined.
interface sqrt_seq_ctrl_if;
    logic        start;
    logic [15:0] datain;
    logic        busy;
    logic        done;
    logic [7:0]  dataout;
`ifdef SQRT_REMAINDER_EN
    logic [8:0]  remainder;
`endif

`ifdef SQRT_REMAINDER_EN
    modport master (output start, output datain,
                    input busy, input done, input dataout, input remainder);
    modport slave  (input start, input datain,
                    output busy, output done, output dataout, output remainder);
`else
    modport master (output start, output datain,
                    input busy, input done, input dataout);
    modport slave  (input start, input datain,
                    output busy, output done, output dataout);
`endif
endinterface

// File: rtl/sqrt_seq_ctrl.sv
// Sequential 16-bit integer square root using odd increments (square += delta, delta += 2).
// Optional feature macro: SQRT_REMAINDER_EN adds the A - root^2 remainder output.
module sqrt_seq_ctrl (
    input  logic           clock,
    input  logic           reset,
    sqrt_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_r;
    logic [15:0] a_r;
    logic [7:0]  root_r;
    logic [16:0] square_r;
    logic [9:0]  delta_r;
    logic        busy_r;
    logic        done_r;
    logic [7:0]  dataout_r;
    logic        le_s;

    // square holds (root+1)^2, so iteration continues while it still fits under A
    assign le_s = (square_r <= {1'b0, a_r});

`ifdef SQRT_REMAINDER_EN
    logic [8:0]  rem_r;
    logic [8:0]  rem_s;

    // square - delta + 2 == root^2; the result fits in 9 bits so modulo-512 math is exact
    assign rem_s = a_r[8:0] - (square_r[8:0] - delta_r[8:0] + 9'd2);

    // Remainder register, loaded alongside dataout
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rem_r <= 9'd0;
        end else if ((state_r == ST_CALC) && !le_s) begin
            rem_r <= rem_s;
        end else begin
            rem_r <= rem_r;
        end
    end

    assign bus.remainder = rem_r;
`endif

    // Control FSM and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            a_r       <= 16'd0;
            root_r    <= 8'd0;
            square_r  <= 17'd1;
            delta_r   <= 10'd3;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            dataout_r <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_r      <= bus.datain;
                        root_r   <= 8'd0;
                        square_r <= 17'd1;
                        delta_r  <= 10'd3;
                        busy_r   <= 1'b1;
                        state_r  <= ST_CALC;
                    end else begin
                        busy_r   <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (le_s) begin
                        square_r <= square_r + {7'd0, delta_r};
                        delta_r  <= delta_r + 10'd2;
                        root_r   <= root_r + 8'd1;
                        state_r  <= ST_CALC;
                    end else begin
                        dataout_r <= root_r;
                        done_r    <= 1'b1;
                        state_r   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.dataout = dataout_r;

endmodule

// File: tb/tb_sqrt_seq_ctrl.sv
// Directed and random checks of sqrt_seq_ctrl: results, remainder, latency and handshake.
module tb_sqrt_seq_ctrl;

    logic clock;
    logic reset;
    int   num_checks;
    int   num_errors;

    sqrt_seq_ctrl_if bus ();

    sqrt_seq_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int isqrt(input int a);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= a) r++;
        return r;
    endfunction

    // One transaction from IDLE; checks result, remainder, latency r+2 and output hold.
    task automatic run_op(input int a, input int exp_r, input string tag);
        int         n;
        logic [7:0] prev;
        bit         glitch;
        prev   = bus.dataout;
        glitch = 1'b0;
        bus.start  = 1'b1;
        bus.datain = a[15:0];
        @(posedge clock); #1;
        n = 1;
        bus.start  = 1'b0;
        bus.datain = 16'($urandom);
        check_eq({tag, "_busy_after_accept"}, {31'd0, bus.busy}, 32'd1);
        while (!bus.done && n < 300) begin
            if (bus.dataout !== prev) glitch = 1'b1;
            @(posedge clock); #1;
            n++;
        end
        check_eq({tag, "_dataout"}, {24'd0, bus.dataout}, exp_r);
        check_eq({tag, "_latency"}, n, exp_r + 2);
        check_eq({tag, "_no_early_change"}, {31'd0, glitch}, 32'd0);
        check_eq({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd1);
`ifdef SQRT_REMAINDER_EN
        check_eq({tag, "_remainder"}, {23'd0, bus.remainder}, a - exp_r * exp_r);
`endif
        @(posedge clock); #1;
        check_eq({tag, "_dataout_held"}, {24'd0, bus.dataout}, exp_r);
        check_eq({tag, "_done_falls"}, {30'd0, bus.done, bus.busy}, 32'd0);
    endtask

    initial begin
        int n;
        int m;
        int a;
        int w;
        num_checks = 0;
        num_errors = 0;
        clock      = 1'b0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.datain = 16'd0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("reset_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("reset_done", {31'd0, bus.done}, 32'd0);
        check_eq("reset_dataout", {24'd0, bus.dataout}, 32'd0);
`ifdef SQRT_REMAINDER_EN
        check_eq("reset_remainder", {23'd0, bus.remainder}, 32'd0);
`endif
        reset = 1'b0;
        @(posedge clock); #1;

        run_op(0, 0, "a0");
        run_op(1, 1, "a1");
        run_op(144, 12, "a144");
        run_op(143, 11, "a143");

        // Reset on the 50th busy cycle of a long operand
        bus.start  = 1'b1;
        bus.datain = 16'd40000;
        @(posedge clock); #1;
        bus.start = 1'b0;
        n = 1;
        while (n < 50 && bus.busy) begin
            @(posedge clock); #1;
            n++;
        end
        check_eq("midcalc_still_busy", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        #1;
        check_eq("midcalc_reset_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("midcalc_reset_done", {31'd0, bus.done}, 32'd0);
        check_eq("midcalc_reset_dataout", {24'd0, bus.dataout}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        run_op(9, 3, "a9_after_reset");

        run_op(65535, 255, "amax");

        // Start held high; datain changes mid-calculation
        bus.start  = 1'b1;
        bus.datain = 16'd100;
        @(posedge clock); #1;
        n = 1;
        while (!bus.done && n < 300) begin
            if (n == 4) bus.datain = 16'd25;
            @(posedge clock); #1;
            n++;
        end
        check_eq("hold_first_dataout", {24'd0, bus.dataout}, 32'd10);
        check_eq("hold_first_latency", n, 32'd12);
        m = 0;
        do begin
            @(posedge clock); #1;
            m++;
            if (m == 1) check_eq("hold_idle_gap_busy", {31'd0, bus.busy}, 32'd0);
        end while (!bus.done && m < 300);
        check_eq("hold_second_dataout", {24'd0, bus.dataout}, 32'd5);
        check_eq("hold_second_gap", m, 32'd8);
        bus.start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("hold_not_requeued", {31'd0, bus.busy}, 32'd0);

        // Random sweep, operand widths varied to cover small and large roots
        for (int i = 0; i < 2000; i++) begin
            w = $urandom_range(1, 14);
            a = int'($urandom & ((32'd1 << (w + 2)) - 32'd1));
            run_op(a, isqrt(a), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
